// File: rtl/im_fetch_arb.sv
// Two-requester (fetch / debug) arbiter for the combinational instruction-memory read port.
// Optional stall statistics are compiled in with `define IM_ARB_STATS_EN.
module im_fetch_arb #(
  parameter int unsigned          ADDR_W        = 16,
  parameter int unsigned          DATA_W        = 32,
  parameter int unsigned          ROM_ADDR_BITS = 5,
  parameter logic [DATA_W-1:0]    NOP_INSTR     = 32'h00000013
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_err_o,
  input  logic              dbg_req_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_err_o,
  input  logic              dbg_lock_i,
  output logic [ADDR_W-1:0] im_pc_o,
  input  logic [DATA_W-1:0] im_instr_i
`ifdef IM_ARB_STATS_EN
  ,
  input  logic              stat_clr_i,
  output logic [15:0]       stat_cpu_stall_o,
  output logic [15:0]       stat_dbg_stall_o
`endif
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_e;
  typedef enum logic {PRIO_CPU = 1'b0, PRIO_DBG = 1'b1} prio_e;

  lock_e lock_q;
  prio_e prio_q, prio_d;

  logic              cpu_blk, contended;
  logic              cpu_gnt, dbg_gnt;
  logic              oor;
  logic [DATA_W-1:0] rd_word;

  logic              cpu_rvalid_q, dbg_rvalid_q, cpu_err_q, dbg_err_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

  // A raised dbg_lock blocks the cpu in the same cycle, before the FSM registers it.
  assign cpu_blk   = (lock_q == LOCKED) || dbg_lock_i;
  assign contended = cpu_req_i && dbg_req_i && !cpu_blk;

  assign cpu_gnt = rst_ni && cpu_req_i && !cpu_blk && (!dbg_req_i || prio_q == PRIO_CPU);
  assign dbg_gnt = rst_ni && dbg_req_i && !cpu_gnt;

  assign cpu_gnt_o = cpu_gnt;
  assign dbg_gnt_o = dbg_gnt;
  assign im_pc_o   = cpu_gnt ? cpu_addr_i : (dbg_gnt ? dbg_addr_i : '0);

  assign oor     = |im_pc_o[ADDR_W-1:ROM_ADDR_BITS];
  assign rd_word = oor ? NOP_INSTR : im_instr_i;

  always_comb begin
    prio_d = prio_q;
    if (contended) prio_d = (prio_q == PRIO_CPU) ? PRIO_DBG : PRIO_CPU;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= UNLOCKED;
      prio_q <= PRIO_CPU;
    end else begin
      prio_q <= prio_d;
      case (lock_q)
        UNLOCKED: if (dbg_lock_i)  lock_q <= LOCKED;
        LOCKED:   if (!dbg_lock_i) lock_q <= UNLOCKED;
        default:                   lock_q <= UNLOCKED;
      endcase
    end
  end

  // Response registers: capture at the granting edge, hold data while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      cpu_err_q    <= 1'b0;
      dbg_err_q    <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_gnt;
      dbg_rvalid_q <= dbg_gnt;
      if (cpu_gnt) begin
        cpu_rdata_q <= rd_word;
        cpu_err_q   <= oor;
      end
      if (dbg_gnt) begin
        dbg_rdata_q <= rd_word;
        dbg_err_q   <= oor;
      end
    end
  end

  assign cpu_rvalid_o = cpu_rvalid_q;
  assign dbg_rvalid_o = dbg_rvalid_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign dbg_rdata_o  = dbg_rdata_q;
  assign cpu_err_o    = cpu_err_q;
  assign dbg_err_o    = dbg_err_q;

`ifdef IM_ARB_STATS_EN
  logic [15:0] cpu_stall_q, dbg_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cpu_stall_q <= '0;
      dbg_stall_q <= '0;
    end else if (stat_clr_i) begin
      cpu_stall_q <= '0;
      dbg_stall_q <= '0;
    end else begin
      if (cpu_req_i && !cpu_gnt && cpu_stall_q != 16'hFFFF) cpu_stall_q <= cpu_stall_q + 16'd1;
      if (dbg_req_i && !dbg_gnt && dbg_stall_q != 16'hFFFF) dbg_stall_q <= dbg_stall_q + 16'd1;
    end
  end

  assign stat_cpu_stall_o = cpu_stall_q;
  assign stat_dbg_stall_o = dbg_stall_q;
`endif

endmodule

// File: tb/tb_im_fetch_arb.sv
// Self-checking bench for im_fetch_arb: directed vector table, reset corner case and
// randomized traffic against a transaction-level reference model.
module tb_im_fetch_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, dbg_req, dbg_lock, stat_clr;
  logic [15:0] cpu_addr, dbg_addr, im_pc;
  logic        cpu_gnt, cpu_rvalid, cpu_err, dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0] cpu_rdata, dbg_rdata, im_instr;
`ifdef IM_ARB_STATS_EN
  logic [15:0] stat_cpu_stall, stat_dbg_stall;
`endif

  logic [31:0] rom [32];
  assign im_instr = rom[im_pc[4:0]];

  always #5 clk = ~clk;

  im_fetch_arb dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr), .cpu_gnt_o(cpu_gnt),
    .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata), .cpu_err_o(cpu_err),
    .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr), .dbg_gnt_o(dbg_gnt),
    .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata), .dbg_err_o(dbg_err),
    .dbg_lock_i(dbg_lock), .im_pc_o(im_pc), .im_instr_i(im_instr)
`ifdef IM_ARB_STATS_EN
    , .stat_clr_i(stat_clr), .stat_cpu_stall_o(stat_cpu_stall), .stat_dbg_stall_o(stat_dbg_stall)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: who owns the port, whose turn it is, and what each requester last received.
  bit          m_prio_dbg, m_locked, m_cv, m_dv, m_cerr, m_derr, mg_c, mg_d;
  logic [31:0] m_cdata, m_ddata;
  int          m_cst, m_dst;

  function automatic logic [31:0] word_at(input logic [15:0] a);
    return (a >= 16'd32) ? 32'h00000013 : rom[a[4:0]];
  endfunction

  task automatic model_reset();
    m_prio_dbg = 0; m_locked = 0; m_cv = 0; m_dv = 0; m_cerr = 0; m_derr = 0;
    m_cdata = 0; m_ddata = 0; m_cst = 0; m_dst = 0;
  endtask

  task automatic step(input bit cr, input logic [15:0] ca, input bit dr, input logic [15:0] da,
                      input bit lk, input bit clr, input bit use_exp, input bit ecg, input bit edg);
    logic [15:0] exp_pc;
    cpu_req = cr; cpu_addr = ca; dbg_req = dr; dbg_addr = da; dbg_lock = lk; stat_clr = clr;
    #1;
    if (m_locked || lk)  begin mg_c = 0;            mg_d = dr;         end
    else if (cr && dr)   begin mg_c = !m_prio_dbg;  mg_d = m_prio_dbg; end
    else                 begin mg_c = cr;           mg_d = dr;         end
    exp_pc = mg_c ? ca : (mg_d ? da : 16'd0);
    if (use_exp) begin
      chk("tbl_cpu_gnt", 32'(cpu_gnt), 32'(ecg));
      chk("tbl_dbg_gnt", 32'(dbg_gnt), 32'(edg));
    end
    chk("cpu_gnt", 32'(cpu_gnt), 32'(mg_c));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(mg_d));
    chk("im_pc", 32'(im_pc), 32'(exp_pc));
    @(posedge clk);
    if (!(m_locked || lk) && cr && dr) m_prio_dbg = !m_prio_dbg;
    m_locked = lk;
    m_cv = mg_c; m_dv = mg_d;
    if (mg_c) begin m_cdata = word_at(ca); m_cerr = (ca >= 16'd32); end
    if (mg_d) begin m_ddata = word_at(da); m_derr = (da >= 16'd32); end
    if (clr) begin m_cst = 0; m_dst = 0; end
    else begin
      if (cr && !mg_c && m_cst < 65535) m_cst++;
      if (dr && !mg_d && m_dst < 65535) m_dst++;
    end
    #1;
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cv));
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_dv));
    chk("cpu_rdata", cpu_rdata, m_cdata);
    chk("dbg_rdata", dbg_rdata, m_ddata);
    chk("cpu_err", 32'(cpu_err), 32'(m_cerr));
    chk("dbg_err", 32'(dbg_err), 32'(m_derr));
`ifdef IM_ARB_STATS_EN
    chk("stat_cpu_stall", 32'(stat_cpu_stall), 32'(m_cst));
    chk("stat_dbg_stall", 32'(stat_dbg_stall), 32'(m_dst));
`endif
    @(negedge clk);
  endtask

  typedef struct {
    bit cr; logic [15:0] ca; bit dr; logic [15:0] da; bit lk; bit ecg; bit edg;
  } vec_t;
  vec_t tbl [15];

  bit          rcr, rdr, rlk;
  logic [15:0] rca, rda;

  initial begin
    tbl[0]  = '{1, 16'h0000, 0, 16'h0000, 0, 1, 0};
    tbl[1]  = '{1, 16'h0001, 0, 16'h0000, 0, 1, 0};
    tbl[2]  = '{1, 16'h0002, 0, 16'h0000, 0, 1, 0};
    tbl[3]  = '{1, 16'h0003, 1, 16'h0004, 0, 1, 0};
    tbl[4]  = '{1, 16'h0003, 1, 16'h0004, 0, 0, 1};
    tbl[5]  = '{1, 16'h0003, 1, 16'h0004, 0, 1, 0};
    tbl[6]  = '{1, 16'h0003, 1, 16'h0004, 0, 0, 1};
    tbl[7]  = '{1, 16'h0007, 1, 16'h0008, 1, 0, 1};
    tbl[8]  = '{1, 16'h0007, 0, 16'h0000, 1, 0, 0};
    tbl[9]  = '{1, 16'h0007, 1, 16'h0009, 1, 0, 1};
    tbl[10] = '{1, 16'h0007, 0, 16'h0000, 0, 0, 0};
    tbl[11] = '{1, 16'h0007, 0, 16'h0000, 0, 1, 0};
    tbl[12] = '{1, 16'h0020, 0, 16'h0000, 0, 1, 0};
    tbl[13] = '{1, 16'h001B, 0, 16'h0000, 0, 1, 0};
    tbl[14] = '{0, 16'h0000, 0, 16'h0000, 0, 0, 0};

    for (int i = 0; i < 32; i++) rom[i] = $urandom;
    rom[0] = 32'h00000293; rom[1] = 32'h00000393; rom[2] = 32'h00100313;
    rom[3] = 32'h100105b7; rom[4] = 32'h0005ae03; rom[27] = 32'hfb9ff06f;

    rst_n = 0; cpu_req = 0; dbg_req = 0; dbg_lock = 0; stat_clr = 0;
    cpu_addr = 0; dbg_addr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dbg_err", 32'(dbg_err), 32'd0);
    chk("rst_im_pc", 32'(im_pc), 32'd0);
    rst_n = 1;

    for (int i = 0; i < 15; i++)
      step(tbl[i].cr, tbl[i].ca, tbl[i].dr, tbl[i].da, tbl[i].lk, 0, 1, tbl[i].ecg, tbl[i].edg);
    chk("oor_nop_hold", cpu_rdata, 32'hfb9ff06f);

    // Reset while a cpu response is in flight; the pointer was left naming dbg.
    step(1, 16'h0005, 1, 16'h0006, 0, 0, 1, 1, 0);
    cpu_req = 1; cpu_addr = 16'h0005; dbg_req = 0;
    #1 chk("pre_rst_cpu_gnt", 32'(cpu_gnt), 32'd1);
    rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_drop_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_drop_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1;
    step(0, 16'h0000, 0, 16'h0000, 0, 0, 1, 0, 0);
    step(1, 16'h0002, 1, 16'h0001, 0, 0, 1, 1, 0);

    // Randomized traffic; requesters hold req/addr until granted.
    rcr = 0; rdr = 0; rlk = 0; rca = 0; rda = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) rlk = !rlk;
      if (!rcr || mg_c) begin
        rcr = 1'($urandom_range(0, 1));
        rca = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      end
      if (!rdr || mg_d) begin
        rdr = 1'($urandom_range(0, 1));
        rda = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      end
      step(rcr, rca, rdr, rda, rlk, 1'($urandom_range(0, 31) == 0), 0, 0, 0);
    end
    step(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0);

`ifdef IM_ARB_STATS_EN
    step(0, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 16'h0003, 1, 16'h0004, 0, 0, 0, 0, 0);
    chk("stall10_cpu", 32'(stat_cpu_stall), 32'd5);
    chk("stall10_dbg", 32'(stat_dbg_stall), 32'd5);
    step(1, 16'h0003, 1, 16'h0004, 0, 1, 0, 0, 0);
    chk("clr_cpu", 32'(stat_cpu_stall), 32'd0);
    chk("clr_dbg", 32'(stat_dbg_stall), 32'd0);
    cpu_req = 1; dbg_req = 0; dbg_lock = 1; stat_clr = 0;
    repeat (70000) @(posedge clk);
    #1 chk("stall_sat", 32'(stat_cpu_stall), 32'h0000FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
